// File: rtl/mult_div_iter_if.sv
// ---------------------------------------------------------------------------
// mult_div_iter_if
//   Bundle between the E stage and the HI/LO multiply-divide unit.
//   master : pipeline side (drives launches and mthi/mtlo writes)
//   slave  : mult_div_iter (returns busy and the architectural HI/LO)
//
//   req         exception in flight; blocks any new launch/write this cycle
//   start, op   launch op (0 mult .. 7 msubu) with operands a, b
//   a, b        rs / rt operands; a is also the mthi/mtlo data
//   mthi, mtlo  write a into HI / LO
//   busy        high while an op is in progress
//   hi, lo      architectural HI / LO
// ---------------------------------------------------------------------------
interface mult_div_iter_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output req, start, op, a, b, mthi, mtlo,
                    input  busy, hi, lo);
    modport slave  (input  req, start, op, a, b, mthi, mtlo,
                    output busy, hi, lo);
endinterface

// File: rtl/mult_div_iter.sv
// ---------------------------------------------------------------------------
// mult_div_iter
//   HI/LO multiply-divide unit for the E stage.
//   - Multiply class: product captured at launch, committed to {hi,lo}
//     after MUL_LAT busy cycles (optionally accumulated / subtracted).
//   - Divide: radix-2 non-restoring, one quotient bit per cycle for WIDTH
//     cycles, then one FIX cycle for remainder and sign correction.
//   Ports:
//     clk    clock
//     reset  synchronous, active-high
//     mdu    mult_div_iter_if.slave (req/start/op/a/b/mthi/mtlo in,
//            busy/hi/lo out, all outputs registered)
//   Optional feature macro: MDU_MACC_EN
//     defined   -> ops 4-7 (madd/maddu/msub/msubu) accumulate into {hi,lo}
//     undefined -> ops 4-7 are no-ops and the accumulate adder is absent
// ---------------------------------------------------------------------------
module mult_div_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int CNT_W   = 6
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_iter_if.slave mdu
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
`ifdef MDU_MACC_EN
    typedef enum logic [1:0] {K_SET, K_ADD, K_SUB} mul_kind_t;
    mul_kind_t mul_kind_q;
`endif

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [2*WIDTH-1:0] prod_q;
    // Divider: signed partial remainder (two guard bits), dividend/quotient
    // shift register and divisor magnitude.
    logic [WIDTH+1:0]   r_q;
    logic [WIDTH-1:0]   q_q, d_q, a_q;
    logic               quo_neg_q, rem_neg_q, div0_q, ovf_q;

    // ---------------- launch decode ----------------
    logic               is_signed, is_div, launch_mul;
    logic               a_neg, b_neg, div0, ovf;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod_d;

    assign is_signed = ~mdu.op[0];
    assign is_div    = (mdu.op[2:1] == 2'b01);
`ifdef MDU_MACC_EN
    assign launch_mul = ~is_div;
`else
    assign launch_mul = (mdu.op[2:1] == 2'b00);
`endif

    // Sign/zero extension to 2*WIDTH makes one modulo-2^(2W) multiply
    // correct for both signed and unsigned operands.
    assign ext_a  = is_signed ? {{WIDTH{mdu.a[WIDTH-1]}}, mdu.a} : {{WIDTH{1'b0}}, mdu.a};
    assign ext_b  = is_signed ? {{WIDTH{mdu.b[WIDTH-1]}}, mdu.b} : {{WIDTH{1'b0}}, mdu.b};
    assign prod_d = ext_a * ext_b;

    assign a_neg = is_signed & mdu.a[WIDTH-1];
    assign b_neg = is_signed & mdu.b[WIDTH-1];
    assign a_mag = a_neg ? -mdu.a : mdu.a;
    assign b_mag = b_neg ? -mdu.b : mdu.b;
    assign div0  = (mdu.b == '0);
    assign ovf   = is_signed && (mdu.a == {1'b1, {(WIDTH-1){1'b0}}}) && (&mdu.b);

    // ---------------- datapath next values ----------------
    logic [WIDTH+1:0]   shift_v, r_d;
    logic [WIDTH-1:0]   q_d, rem_mag, hi_fix, lo_fix;
    logic [2*WIDTH-1:0] acc_d;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        shift_v = {r_q[WIDTH:0], q_q[WIDTH-1]};
        r_d     = '0;
        // Non-restoring step: subtract while the remainder is non-negative,
        // add back the divisor while it is negative.
        if (r_q[WIDTH+1]) r_d = shift_v + {2'b00, d_q};
        else              r_d = shift_v - {2'b00, d_q};
        q_d = {q_q[WIDTH-2:0], ~r_d[WIDTH+1]};

        // Final correction brings a negative remainder back into [0, d).
        rem_mag = r_q[WIDTH+1] ? r_q[WIDTH-1:0] + d_q : r_q[WIDTH-1:0];
        hi_fix  = rem_neg_q ? -rem_mag : rem_mag;
        lo_fix  = quo_neg_q ? -q_q : q_q;

        acc_d = prod_q;
`ifdef MDU_MACC_EN
        case (mul_kind_q)
            K_ADD:   acc_d = {hi_q, lo_q} + prod_q;
            K_SUB:   acc_d = {hi_q, lo_q} - prod_q;
            default: acc_d = prod_q;
        endcase
`endif
    end

    // ---------------- FSM and state ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            prod_q    <= '0;
            r_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            a_q       <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef MDU_MACC_EN
            mul_kind_q <= K_SET;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!mdu.req) begin
                        if (mdu.mthi) begin
                            hi_q <= mdu.a;
                        end else if (mdu.mtlo) begin
                            lo_q <= mdu.a;
                        end else if (mdu.start && is_div) begin
                            r_q       <= '0;
                            q_q       <= a_mag;
                            d_q       <= b_mag;
                            a_q       <= mdu.a;
                            quo_neg_q <= a_neg ^ b_neg;
                            rem_neg_q <= a_neg;
                            div0_q    <= div0;
                            ovf_q     <= ovf;
                            cnt_q     <= CNT_W'(WIDTH);
                            busy_q    <= 1'b1;
                            state_q   <= S_DIV;
                        end else if (mdu.start && launch_mul) begin
                            prod_q  <= prod_d;
`ifdef MDU_MACC_EN
                            case (mdu.op[2:1])
                                2'b10:   mul_kind_q <= K_ADD;
                                2'b11:   mul_kind_q <= K_SUB;
                                default: mul_kind_q <= K_SET;
                            endcase
`endif
                            cnt_q   <= CNT_W'(MUL_LAT);
                            busy_q  <= 1'b1;
                            state_q <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        {hi_q, lo_q} <= acc_d;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                S_DIV: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    if (div0_q) begin
                        hi_q <= a_q;
                        lo_q <= '1;
                    end else if (ovf_q) begin
                        hi_q <= '0;
                        lo_q <= a_q;
                    end else begin
                        hi_q <= hi_fix;
                        lo_q <= lo_fix;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mdu.busy = busy_q;
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_iter.sv
// ---------------------------------------------------------------------------
// tb_mult_div_iter
//   Directed bench for mult_div_iter. Expected HI/LO/latency are pushed to a
//   scoreboard queue when an op is launched and popped when busy falls.
// ---------------------------------------------------------------------------
module tb_mult_div_iter;
    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 5;
    localparam int CNT_W   = 6;
    localparam int DIV_LAT = WIDTH + 1;

    typedef struct {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        int               lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic [WIDTH-1:0] model_hi, model_lo;

    mult_div_iter_if #(.WIDTH(WIDTH)) mdu ();

    mult_div_iter #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mdu)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Launch one op, then measure busy width and compare against the queue.
    // poke > 0 drives a second start during busy cycle number poke.
    task automatic run_op(input string tag, input logic [2:0] op_v,
                          input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                          input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el,
                          input int elat, input int poke);
        exp_t e;
        int   n;
        e.hi = eh; e.lo = el; e.lat = elat;
        sb.push_back(e);
        mdu.op = op_v; mdu.a = a_v; mdu.b = b_v; mdu.start = 1'b1;
        @(posedge clk); @(negedge clk);
        mdu.start = 1'b0;
        check({tag, "_hold_hi"}, 64'(mdu.hi), 64'(model_hi));
        check({tag, "_hold_lo"}, 64'(mdu.lo), 64'(model_lo));
        n = 0;
        while (mdu.busy === 1'b1 && n < 200) begin
            n++;
            if (n == poke) begin
                mdu.start = 1'b1; mdu.op = 3'd1; mdu.a = 1; mdu.b = 1;
            end else begin
                mdu.start = 1'b0;
            end
            @(negedge clk);
        end
        mdu.start = 1'b0;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(0), 64'(1));
        end else begin
            e = sb.pop_front();
            check({tag, "_lat"}, 64'(n), 64'(e.lat));
            check({tag, "_hi"}, 64'(mdu.hi), 64'(e.hi));
            check({tag, "_lo"}, 64'(mdu.lo), 64'(e.lo));
            model_hi = e.hi;
            model_lo = e.lo;
        end
    endtask

    task automatic write_hilo(input logic wh, input logic wl, input logic [WIDTH-1:0] d);
        mdu.mthi = wh; mdu.mtlo = wl; mdu.a = d;
        @(posedge clk); @(negedge clk);
        mdu.mthi = 1'b0; mdu.mtlo = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0]        ra, rb;
        logic [2*WIDTH-1:0]      p;
        logic signed [WIDTH-1:0] sa, sb_v;

        reset = 1'b1;
        mdu.req = 1'b0; mdu.start = 1'b0; mdu.op = '0;
        mdu.a = '0; mdu.b = '0; mdu.mthi = 1'b0; mdu.mtlo = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(mdu.busy), 64'(0));
        check("reset_hi", 64'(mdu.hi), 64'(0));
        check("reset_lo", 64'(mdu.lo), 64'(0));
        model_hi = '0; model_lo = '0;

        run_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT, 0);
        run_op("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT, 0);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, 0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT, 0);
        run_op("divu_by0", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DIV_LAT, 0);
        run_op("div_by0", 3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_LAT, 0);

        write_hilo(1'b1, 1'b0, 32'd1);
        check("mthi_hi", 64'(mdu.hi), 64'(1));
        check("mthi_busy", 64'(mdu.busy), 64'(0));
        write_hilo(1'b0, 1'b1, 32'd0);
        check("mtlo_lo", 64'(mdu.lo), 64'(0));
        model_hi = 32'd1; model_lo = 32'd0;
`ifdef MDU_MACC_EN
        run_op("madd", 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, MUL_LAT, 0);
        run_op("msubu", 3'd7, 32'd2, 32'd3, 32'h0, 32'hFFFF_FFF9, MUL_LAT, 0);
`else
        run_op("madd", 3'd4, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 0, 0);
        run_op("msubu", 3'd7, 32'd2, 32'd3, 32'd1, 32'd0, 0, 0);
`endif

        // Launch blocked by req.
        mdu.req = 1'b1; mdu.op = 3'd0; mdu.a = 32'd2; mdu.b = 32'd3; mdu.start = 1'b1;
        @(posedge clk); @(negedge clk);
        mdu.start = 1'b0; mdu.req = 1'b0;
        check("req_busy", 64'(mdu.busy), 64'(0));
        check("req_hi", 64'(mdu.hi), 64'(model_hi));
        check("req_lo", 64'(mdu.lo), 64'(model_lo));

        // mthi wins over mtlo.
        write_hilo(1'b1, 1'b1, 32'd9);
        check("both_hi", 64'(mdu.hi), 64'(9));
        check("both_lo", 64'(mdu.lo), 64'(model_lo));
        model_hi = 32'd9;

        // Randomised operands against a reference built from SV arithmetic.
        for (int i = 0; i < 3; i++) begin
            ra = $urandom; rb = $urandom;
            p = 64'(longint'($signed(ra)) * longint'($signed(rb)));
            run_op("rnd_mult", 3'd0, ra, rb, p[63:32], p[31:0], MUL_LAT, 0);
            p = {32'b0, ra} * {32'b0, rb};
            run_op("rnd_multu", 3'd1, ra, rb, p[63:32], p[31:0], MUL_LAT, 0);
            rb = rb | 32'd1;
            run_op("rnd_divu", 3'd3, ra, rb, ra % rb, ra / rb, DIV_LAT, 0);
            sa = $signed(ra); sb_v = $signed(rb >> $urandom_range(0, 20));
            run_op("rnd_div", 3'd2, sa, sb_v, sa % sb_v, sa / sb_v, DIV_LAT, 0);
        end

        // Start during busy is ignored.
        run_op("poke", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT, 3);

        // Reset on busy cycle 10 of a divu aborts it.
        mdu.op = 3'd3; mdu.a = 32'd100; mdu.b = 32'd7; mdu.start = 1'b1;
        @(posedge clk); @(negedge clk);
        mdu.start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy", 64'(mdu.busy), 64'(1));
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 64'(mdu.busy), 64'(0));
        check("rst_hi", 64'(mdu.hi), 64'(0));
        check("rst_lo", 64'(mdu.lo), 64'(0));
        model_hi = '0; model_lo = '0;

        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
